ecc_sed_pipe_encoder: RTL and testbench

//  Parametrised single-error-detect (parity) encoder with interleaved parity groups, selectable

---
 rtl/ecc_sed_pipe_encoder.sv | 105 ++++++++++
 tb/tb_ecc_sed_pipe_encoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_sed_pipe_encoder.sv
// Single-error-detect parity encoder with interleaved parity groups,
// a registered output stage, a one-entry skid buffer, a one-shot
// parity-corruption hook and a saturating accepted-beat counter.
module ecc_sed_pipe_encoder #(
    parameter int DATA_W     = 12,
    parameter int GROUPS     = 1,
    parameter int ODD_PARITY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W+GROUPS-1:0] out_codeword,
    input  logic                     inj_arm,
    output logic                     inj_pending,
    output logic [CNT_W-1:0]         beat_cnt
);

    localparam int   CW_W    = DATA_W + GROUPS;
    localparam logic ODD_BIT = (ODD_PARITY != 0);

    // Group g covers every data bit whose index is congruent to g mod GROUPS.
    function automatic logic [GROUPS-1:0] parity_of(input logic [DATA_W-1:0] d);
        logic [GROUPS-1:0] p;
        p = {GROUPS{ODD_BIT}};
        for (int g = 0; g < GROUPS; g++) begin
            for (int i = 0; i < DATA_W; i++) begin
                if ((i % GROUPS) == g) begin
                    p[g] = p[g] ^ d[i];
                end
            end
        end
        return p;
    endfunction

    logic              accept;
    logic              or_free;
    logic              corrupt;
    logic              sk_vld;
    logic              sk_vld_next;
    logic [GROUPS-1:0] par_p0;
    logic [CW_W-1:0]   cw_p0;
    logic [CW_W-1:0]   sk_cw;

    assign accept  = in_valid && in_ready;
    // OR can take a new codeword when it is empty or is being emptied now.
    assign or_free = !out_valid || out_ready;
    // A same-cycle arm also hits the beat being accepted.
    assign corrupt = accept && (inj_pending || inj_arm);
    // in_ready is high only while SK is empty, so SK never fills while already valid.
    assign sk_vld_next = or_free ? 1'b0 : (sk_vld || accept);

    // Stage p0: encode the incoming beat, flipping parity[0] when injecting.
    always_comb begin
        par_p0    = parity_of(in_data);
        par_p0[0] = par_p0[0] ^ corrupt;
        cw_p0     = {par_p0, in_data};
    end

    // Control state: output register, skid valid, ready, injection and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_codeword <= '0;
            sk_vld       <= 1'b0;
            in_ready     <= 1'b0;
            inj_pending  <= 1'b0;
            beat_cnt     <= '0;
        end else begin
            if (or_free) begin
                if (sk_vld) begin
                    out_valid    <= 1'b1;
                    out_codeword <= sk_cw;
                end else if (accept) begin
                    out_valid    <= 1'b1;
                    out_codeword <= cw_p0;
                end else begin
                    out_valid    <= 1'b0;
                end
            end
            sk_vld   <= sk_vld_next;
            in_ready <= !sk_vld_next;
            if (accept) begin
                inj_pending <= 1'b0;
            end else if (inj_arm) begin
                inj_pending <= 1'b1;
            end
            if (accept && (beat_cnt != {CNT_W{1'b1}})) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Stage p1: skid entry captures a full codeword when OR is stalled.
    always_ff @(posedge clk) begin
        if (accept && !or_free) begin
            sk_cw <= cw_p0;
        end
    end

endmodule

// File: tb/tb_ecc_sed_pipe_encoder.sv
// Directed bench for ecc_sed_pipe_encoder: table of encodings for two
// parity configurations, then backpressure, reset, full-rate, injection
// and counter-saturation sequences.
module tb_ecc_sed_pipe_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [11:0] in_data;
    logic        out_ready;
    logic        inj_arm;

    logic        in_ready1, out_valid1, inj_pending1;
    logic [12:0] cw1;
    logic [15:0] cnt1;
    logic        in_ready2, out_valid2, inj_pending2;
    logic [13:0] cw2;
    logic [15:0] cnt2;
    logic        in_ready3, out_valid3, inj_pending3;
    logic [12:0] cw3;
    logic [1:0]  cnt3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ecc_sed_pipe_encoder #(.DATA_W(12), .GROUPS(1), .ODD_PARITY(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_codeword(cw1),
        .inj_arm(inj_arm), .inj_pending(inj_pending1), .beat_cnt(cnt1));

    ecc_sed_pipe_encoder #(.DATA_W(12), .GROUPS(2), .ODD_PARITY(0), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_codeword(cw2),
        .inj_arm(inj_arm), .inj_pending(inj_pending2), .beat_cnt(cnt2));

    ecc_sed_pipe_encoder #(.DATA_W(12), .GROUPS(1), .ODD_PARITY(1), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .out_valid(out_valid3), .out_ready(out_ready), .out_codeword(cw3),
        .inj_arm(inj_arm), .inj_pending(inj_pending3), .beat_cnt(cnt3));

    typedef struct {
        logic [11:0] data;
        logic [12:0] exp1;
        logic [13:0] exp2;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] bp_data[4];
    logic [12:0] bp_exp[4];
    logic [12:0] got[4];
    int idx, ngot, nout, drops, order_err, acc_cnt;
    logic acc;
    logic [11:0] next_out;

    initial begin
        vecs[0] = '{12'h000, 13'h1000, 14'h0000};
        vecs[1] = '{12'h001, 13'h0001, 14'h1001};
        vecs[2] = '{12'h003, 13'h1003, 14'h3003};
        vecs[3] = '{12'hFFF, 13'h1FFF, 14'h0FFF};
        vecs[4] = '{12'h007, 13'h0007, 14'h2007};
        vecs[5] = '{12'hA5A, 13'h1A5A, 14'h0A5A};
        vecs[6] = '{12'h800, 13'h0800, 14'h2800};
        vecs[7] = '{12'h555, 13'h1555, 14'h0555};
        bp_data = '{12'h101, 12'h102, 12'h103, 12'h104};
        bp_exp  = '{13'h1101, 13'h1102, 13'h0103, 13'h1104};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; inj_arm = 1'b0;
        step(); step();
        check("rst_out_valid", 32'(out_valid1), 32'd0);
        check("rst_codeword", 32'(cw1), 32'd0);
        check("rst_in_ready", 32'(in_ready1), 32'd0);
        check("rst_inj_pending", 32'(inj_pending1), 32'd0);
        check("rst_beat_cnt", 32'(cnt1), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready1), 32'd1);

        // Table of encodings, one beat per cycle, latency 1
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            step();
            check($sformatf("vec%0d_valid", i), 32'(out_valid1), 32'd1);
            check($sformatf("vec%0d_cw_g1odd", i), 32'(cw1), 32'(vecs[i].exp1));
            check($sformatf("vec%0d_cw_g2even", i), 32'(cw2), 32'(vecs[i].exp2));
        end
        in_valid = 1'b0;
        step();
        check("table_drained", 32'(out_valid1), 32'd0);
        check("table_beat_cnt", 32'(cnt1), 32'd8);
        check("sat_beat_cnt", 32'(cnt3), 32'd3);

        // Backpressure: four beats offered with out_ready low
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = bp_data[idx];
            acc = in_ready1;
            step();
            if (acc) idx++;
            if (idx == 2 && c >= 1) check("bp_in_ready_low", 32'(in_ready1), 32'd0);
        end
        check("bp_accepted", 32'(idx), 32'd2);
        check("bp_or_stable", 32'(cw1), 32'(bp_exp[0]));
        out_ready = 1'b1;
        ngot = 0;
        for (int c = 0; c < 20 && ngot < 4; c++) begin
            in_valid = (idx < 4);
            in_data  = bp_data[idx < 4 ? idx : 3];
            if (out_valid1 && out_ready) begin
                got[ngot] = cw1;
                ngot++;
            end
            acc = in_valid && in_ready1;
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("bp_out_count", 32'(ngot), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < ngot) check($sformatf("bp_out%0d", k), 32'(got[k]), 32'(bp_exp[k]));
        end
        step(); step();
        check("bp_drained", 32'(out_valid1), 32'd0);

        // Fill OR and SK, arm injection, then reset
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 12'h0AA; step();
        in_data = 12'h0BB; step();
        in_valid = 1'b0; inj_arm = 1'b1; step();
        inj_arm = 1'b0;
        check("full_in_ready", 32'(in_ready1), 32'd0);
        check("full_inj_pending", 32'(inj_pending1), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_full_out_valid", 32'(out_valid1), 32'd0);
        check("rst_full_beat_cnt", 32'(cnt1), 32'd0);
        check("rst_full_inj", 32'(inj_pending1), 32'd0);
        check("rst_full_in_ready0", 32'(in_ready1), 32'd0);
        step();
        check("rst_full_in_ready1", 32'(in_ready1), 32'd1);
        check("rst_full_still_empty", 32'(out_valid1), 32'd0);

        // Full rate: 100 beats back to back
        out_ready = 1'b1;
        nout = 0; drops = 0; order_err = 0; acc_cnt = 0;
        next_out = '0;
        for (int c = 0; c < 101; c++) begin
            in_valid = (c < 100);
            in_data  = 12'(c);
            if (c < 100 && !in_ready1) drops++;
            if (out_valid1 && out_ready) begin
                if (cw1[11:0] != next_out) order_err++;
                next_out = next_out + 12'd1;
                nout++;
            end
            if (in_valid && in_ready1) acc_cnt++;
            step();
        end
        in_valid = 1'b0;
        check("fr_in_ready_drops", 32'(drops), 32'd0);
        check("fr_out_count", 32'(nout), 32'd100);
        check("fr_order", 32'(order_err), 32'd0);
        check("fr_beat_cnt", 32'(cnt1), 32'd100);
        step();

        // Injection: arm, idle, then two zero beats
        inj_arm = 1'b1; step();
        inj_arm = 1'b0;
        check("inj_pending_set", 32'(inj_pending1), 32'd1);
        inj_arm = 1'b1; step();
        inj_arm = 1'b0; step();
        check("inj_pending_hold", 32'(inj_pending1), 32'd1);
        in_valid = 1'b1; in_data = 12'h000; step();
        check("inj_beat1_g1", 32'(cw1), 32'h0000);
        check("inj_beat1_g2", 32'(cw2), 32'h1000);
        check("inj_pending_clr", 32'(inj_pending1), 32'd0);
        step();
        check("inj_beat2_g1", 32'(cw1), 32'h1000);
        check("inj_beat2_g2", 32'(cw2), 32'h0000);

        // Arm coincident with an accept corrupts that beat only
        inj_arm = 1'b1; in_data = 12'h001; step();
        inj_arm = 1'b0;
        check("inj_same_g1", 32'(cw1), 32'h1001);
        check("inj_same_pending", 32'(inj_pending1), 32'd0);
        step();
        check("inj_after_g1", 32'(cw1), 32'h0001);
        in_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
